// File: rtl/lcd_frame_pkg.sv
// Shared timing defaults, FSM state type and pixel-format helpers for the LCD read path.
// The colour-bar helper is used only when LCD_TEST_PATTERN_EN is defined.
package lcd_frame_pkg;

   localparam int unsigned DEF_H_ACTIVE = 800;
   localparam int unsigned DEF_H_FP     = 40;
   localparam int unsigned DEF_H_SYNC   = 128;
   localparam int unsigned DEF_H_BP     = 88;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 1;
   localparam int unsigned DEF_V_SYNC   = 3;
   localparam int unsigned DEF_V_BP     = 21;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      RUN
   } state_e;

   function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return act + fp + sync + bp;
   endfunction

   // Inverse of the write-side packing: wr1={0,G[11:7],B[11:2]}, wr2={0,G[6:2],R[11:2]}
   function automatic logic [23:0] unpack_rgb(input logic [15:0] rd1, input logic [15:0] rd2);
      return {rd2[9:2], rd1[14:10], rd2[14:12], rd1[9:2]};
   endfunction

   function automatic logic [23:0] bar_rgb(input logic [2:0] bar);
      logic [23:0] c;
      c = '0;
      case (bar)
         3'd0: c = 24'hFFFFFF;
         3'd1: c = 24'hFFFF00;
         3'd2: c = 24'h00FFFF;
         3'd3: c = 24'h00FF00;
         3'd4: c = 24'hFF00FF;
         3'd5: c = 24'hFF0000;
         3'd6: c = 24'h0000FF;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/lcd_timing_gen.sv
// Free-running H/V counters with sync, active-area and frame-boundary flags.
// Display-agnostic so other panels can reuse it with their own geometry.
module lcd_timing_gen
   import lcd_frame_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] h_cnt,
   output logic [15:0] v_cnt,
   output logic        active,
   output logic        hsync_n,
   output logic        vsync_n,
   output logic        pre_frame_end,
   output logic        frame_end
);

   localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);

   logic [15:0] h_q, h_d;
   logic [15:0] v_q, v_d;

   always_comb begin
      h_d = h_q + 16'd1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign h_cnt         = h_q;
   assign v_cnt         = v_q;
   assign active        = (h_q < 16'(H_ACTIVE)) && (v_q < 16'(V_ACTIVE));
   assign hsync_n       = !((h_q >= 16'(H_ACTIVE + H_FP)) && (h_q < 16'(H_ACTIVE + H_FP + H_SYNC)));
   assign vsync_n       = !((v_q >= 16'(V_ACTIVE + V_FP)) && (v_q < 16'(V_ACTIVE + V_FP + V_SYNC)));
   assign frame_end     = (h_q == H_LAST) && (v_q == V_LAST);
   assign pre_frame_end = (h_q == 16'(H_TOTAL - 2)) && (v_q == V_LAST);

endmodule

// File: rtl/lcd_frame_reader.sv
// Frame-buffer read side: pops packed pixel pairs, unpacks to RGB888 and drives LCD timing.
// Optional colour-bar source enabled by defining LCD_TEST_PATTERN_EN.
module lcd_frame_reader
   import lcd_frame_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iEnable,
`ifdef LCD_TEST_PATTERN_EN
   input  logic        iTestPattern,
`endif
   input  logic [15:0] iRd1_data,
   input  logic [15:0] iRd2_data,
   input  logic        iRd_empty,
   output logic        oRd_req,
   output logic        oFrameStart,
   output logic [7:0]  oLCD_R,
   output logic [7:0]  oLCD_G,
   output logic [7:0]  oLCD_B,
   output logic        oHSYNC,
   output logic        oVSYNC,
   output logic        oDE,
   output logic [15:0] oX_Cont,
   output logic [15:0] oY_Cont,
   output logic        oUnderflow
);

   logic [15:0] h_cnt, v_cnt;
   logic        active, hsync_n, vsync_n, pre_frame_end, frame_end;

   lcd_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk           (iClk),
      .rst           (iRst),
      .h_cnt         (h_cnt),
      .v_cnt         (v_cnt),
      .active        (active),
      .hsync_n       (hsync_n),
      .vsync_n       (vsync_n),
      .pre_frame_end (pre_frame_end),
      .frame_end     (frame_end)
   );

   state_e      state_q, state_d;
   logic        frame_start;
   logic        rd_req;
   logic        tp_on;
   logic        pix_ok_q, pix_ok_d;
   logic        und_q, und_d;
   logic        de_q, hs_q, vs_q;
   logic [15:0] x_q, y_q;
   logic        tp_de;
   logic [23:0] tp_rgb;
   logic [23:0] rgb;

   // iEnable is taken one cycle ahead of the wrap so ARMED occupies the wrap cycle
   // itself; RUN is then live for pixel (0,0) of the new frame.
   always_comb begin
      state_d     = state_q;
      frame_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (pre_frame_end && iEnable) state_d = ARMED;
         end
         ARMED: begin
            if (frame_end) begin
               state_d     = RUN;
               frame_start = 1'b1;
            end
         end
         RUN: begin
            if (frame_end) begin
               if (iEnable) frame_start = 1'b1;
               else         state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_req   = (state_q == RUN) && active && !tp_on;
      pix_ok_d = rd_req && !iRd_empty;
      und_d    = frame_start ? 1'b0 : (und_q || (rd_req && iRd_empty));
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q  <= IDLE;
         pix_ok_q <= 1'b0;
         und_q    <= 1'b0;
         de_q     <= 1'b0;
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         x_q      <= '0;
         y_q      <= '0;
      end else begin
         state_q  <= state_d;
         pix_ok_q <= pix_ok_d;
         und_q    <= und_d;
         de_q     <= active;
         hs_q     <= hsync_n;
         vs_q     <= vsync_n;
         x_q      <= h_cnt;
         y_q      <= v_cnt;
      end
   end

`ifdef LCD_TEST_PATTERN_EN
   logic        tp_de_q, tp_de_d;
   logic [23:0] tp_rgb_q, tp_rgb_d;
   logic [2:0]  bar_idx;

   always_comb begin
      bar_idx  = 3'((32'(h_cnt) * 32'd8) / H_ACTIVE);
      tp_de_d  = active && iTestPattern;
      tp_rgb_d = bar_rgb(bar_idx);
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         tp_de_q  <= 1'b0;
         tp_rgb_q <= '0;
      end else begin
         tp_de_q  <= tp_de_d;
         tp_rgb_q <= tp_rgb_d;
      end
   end

   assign tp_on  = iTestPattern;
   assign tp_de  = tp_de_q;
   assign tp_rgb = tp_rgb_q;
`else
   assign tp_on  = 1'b0;
   assign tp_de  = 1'b0;
   assign tp_rgb = '0;
`endif

   // FIFO data arrives the cycle after the pop, already aligned with the registered DE.
   always_comb begin
      rgb = '0;
      if (pix_ok_q)   rgb = unpack_rgb(iRd1_data, iRd2_data);
      else if (tp_de) rgb = tp_rgb;
   end

   assign {oLCD_R, oLCD_G, oLCD_B} = rgb;
   assign oRd_req     = rd_req;
   assign oFrameStart = frame_start;
   assign oHSYNC      = hs_q;
   assign oVSYNC      = vs_q;
   assign oDE         = de_q;
   assign oX_Cont     = x_q;
   assign oY_Cont     = y_q;
   assign oUnderflow  = und_q;

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Directed bench for lcd_frame_reader on a 14x7-clock toy panel (8x4 active).
// Colour-bar checks are compiled in when LCD_TEST_PATTERN_EN is defined.
module tb_lcd_frame_reader;

   localparam int unsigned FRAME = 98;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic        tp  = 1'b0;
   logic [15:0] rd1 = '0;
   logic [15:0] rd2 = '0;
   logic        empty = 1'b0;

   logic        rd_req, frame_start, hsync, vsync, de, underflow;
   logic [7:0]  r, g, b;
   logic [15:0] x_cont, y_cont;
   logic [23:0] rgb;

   int checks   = 0;
   int failures = 0;

   int pops, fs_cnt, hs_low, vs_low, rgb_nz, pix_err, zero_pix, und_cnt, pop_idx;
   int under_at = 0;
   logic        pend = 1'b0;
   logic [23:0] exp_pend = '0;
   logic [23:0] last_pix = '0;
   logic [15:0] mode_rd1 = 16'h7FFC;
   logic [15:0] mode_rd2 = 16'h7FFC;
   logic [23:0] mode_rgb = 24'hFFFFFF;
   logic [23:0] tp_col [8];

   lcd_frame_reader #(
      .H_ACTIVE (8),
      .H_FP     (2),
      .H_SYNC   (2),
      .H_BP     (2),
      .V_ACTIVE (4),
      .V_FP     (1),
      .V_SYNC   (1),
      .V_BP     (1)
   ) dut (
      .iClk         (clk),
      .iRst         (rst),
      .iEnable      (en),
`ifdef LCD_TEST_PATTERN_EN
      .iTestPattern (tp),
`endif
      .iRd1_data    (rd1),
      .iRd2_data    (rd2),
      .iRd_empty    (empty),
      .oRd_req      (rd_req),
      .oFrameStart  (frame_start),
      .oLCD_R       (r),
      .oLCD_G       (g),
      .oLCD_B       (b),
      .oHSYNC       (hsync),
      .oVSYNC       (vsync),
      .oDE          (de),
      .oX_Cont      (x_cont),
      .oY_Cont      (y_cont),
      .oUnderflow   (underflow)
   );

   assign rgb = {r, g, b};

   always #5 clk = ~clk;

   // Read FIFO model: one-cycle latency, data refreshed on each pop.
   always @(posedge clk) begin
      if (rd_req) begin
         rd1 <= mode_rd1;
         rd2 <= mode_rd2;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic set_mode(input logic [15:0] a, input logic [15:0] c, input logic [23:0] px);
      mode_rd1 = a;
      mode_rd2 = c;
      mode_rgb = px;
   endtask

   task automatic clear_stats();
      pops = 0; fs_cnt = 0; hs_low = 0; vs_low = 0; rgb_nz = 0;
      pix_err = 0; zero_pix = 0; und_cnt = 0; pop_idx = 0;
   endtask

   task automatic sample();
      if (pend) begin
         if (!de || rgb !== exp_pend) pix_err++;
         if (rgb == 24'h0) zero_pix++;
         last_pix = rgb;
      end else if (de && rgb != 24'h0 && !tp) begin
         pix_err++;
      end
      if (rgb != 24'h0) rgb_nz++;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (frame_start) fs_cnt++;
      if (underflow) und_cnt++;
      if (de && y_cont == 16'd0 && x_cont < 16'd8) tp_col[x_cont[2:0]] = rgb;
      if (rd_req) begin
         pops++;
         pop_idx++;
         empty = (pop_idx == under_at);
      end else begin
         empty = 1'b0;
      end
      pend     = rd_req;
      exp_pend = empty ? 24'h0 : mode_rgb;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         sample();
         @(negedge clk);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req"},   32'(rd_req),      32'd0);
      check({tag, "_fs"},    32'(frame_start), 32'd0);
      check({tag, "_de"},    32'(de),          32'd0);
      check({tag, "_hs"},    32'(hsync),       32'd1);
      check({tag, "_vs"},    32'(vsync),       32'd1);
      check({tag, "_rgb"},   32'(rgb),         32'd0);
      check({tag, "_und"},   32'(underflow),   32'd0);
      check({tag, "_x"},     32'(x_cont),      32'd0);
      check({tag, "_y"},     32'(y_cont),      32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_values("rst");

      // Idle: timing only
      rst = 1'b0;
      clear_stats();
      run_cycles(2 * FRAME);
      check("idle_pops", 32'(pops),   32'd0);
      check("idle_hs",   32'(hs_low), 32'd28);
      check("idle_vs",   32'(vs_low), 32'd28);
      check("idle_rgb",  32'(rgb_nz), 32'd0);
      check("idle_fs",   32'(fs_cnt), 32'd0);

      // Arming frame, then running frames with several pixel formats
      en = 1'b1;
      clear_stats();
      run_cycles(FRAME);
      check("arm_fs",   32'(fs_cnt), 32'd1);
      check("arm_pops", 32'(pops),   32'd0);

      clear_stats();
      run_cycles(FRAME);
      check("white_fs",   32'(fs_cnt),   32'd1);
      check("white_pops", 32'(pops),     32'd32);
      check("white_err",  32'(pix_err),  32'd0);
      check("white_pix",  32'(last_pix), 32'hFFFFFF);

      set_mode(16'h0000, 16'h03FC, 24'hFF0000);
      clear_stats();
      run_cycles(FRAME);
      check("red_pops", 32'(pops),     32'd32);
      check("red_err",  32'(pix_err),  32'd0);
      check("red_pix",  32'(last_pix), 32'hFF0000);

      set_mode(16'h7C00, 16'h7000, 24'h00FF00);
      clear_stats();
      run_cycles(FRAME);
      check("green_pops", 32'(pops),     32'd32);
      check("green_err",  32'(pix_err),  32'd0);
      check("green_pix",  32'(last_pix), 32'h00FF00);

      // Underflow on pop #5
      set_mode(16'h7FFC, 16'h7FFC, 24'hFFFFFF);
      under_at = 5;
      clear_stats();
      run_cycles(FRAME);
      check("und_pops", 32'(pops),     32'd32);
      check("und_cnt",  32'(und_cnt),  32'd93);
      check("und_zero", 32'(zero_pix), 32'd1);
      check("und_err",  32'(pix_err),  32'd0);
      under_at = 0;
      clear_stats();
      run_cycles(FRAME);
      check("und_clr",  32'(und_cnt),  32'd0);
      check("und_zero2", 32'(zero_pix), 32'd0);

      // Drop enable at line 2
      clear_stats();
      run_cycles(28);
      en = 1'b0;
      run_cycles(FRAME - 28);
      check("drop_pops", 32'(pops),   32'd32);
      check("drop_fs",   32'(fs_cnt), 32'd0);
      clear_stats();
      run_cycles(FRAME);
      check("off_pops", 32'(pops),   32'd0);
      check("off_fs",   32'(fs_cnt), 32'd0);
      check("off_hs",   32'(hs_low), 32'd14);
      check("off_vs",   32'(vs_low), 32'd14);
      check("off_rgb",  32'(rgb_nz), 32'd0);

      en = 1'b1;
      clear_stats();
      run_cycles(FRAME);
      check("rearm_fs", 32'(fs_cnt), 32'd1);

`ifdef LCD_TEST_PATTERN_EN
      tp = 1'b1;
      clear_stats();
      run_cycles(FRAME);
      check("tp_pops", 32'(pops),      32'd0);
      check("tp_und",  32'(und_cnt),   32'd0);
      check("tp_x0",   32'(tp_col[0]), 32'hFFFFFF);
      check("tp_x1",   32'(tp_col[1]), 32'hFFFF00);
      check("tp_x7",   32'(tp_col[7]), 32'h000000);
      tp = 1'b0;
`endif

      // Reset during pixel 3 of line 1
      run_cycles(17);
      check("pre_rst_req", 32'(rd_req), 32'd1);
      rst = 1'b1;
      #1;
      check_reset_values("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("restart_x0",  32'(x_cont), 32'd0);
      check("restart_y0",  32'(y_cont), 32'd0);
      check("restart_req", 32'(rd_req), 32'd0);
      @(posedge clk); #1;
      check("restart_x1",  32'(x_cont), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
